// File: rtl/scan_pkg.sv
// Shared types and helpers for the window scan controller.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } scan_state_e;

  // Counter width for n positions, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter.sv
// Up/down counter with synchronous active-high clear and a look-ahead next value.
module counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] next_count_o
);

  logic [Width-1:0] r_count;

  always_comb begin
    next_count_o = r_count;
    if (up_i && !down_i) begin
      next_count_o = r_count + Width'(1);
    end else if (down_i && !up_i) begin
      next_count_o = r_count - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      r_count <= next_count_o;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster scan controller: walks one frame pixel by pixel and flags pixels that
// complete a full KernelSize x KernelSize window.
module window_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned ImgWidth   = 64,
  parameter int unsigned ImgHeight  = 48,
  parameter int unsigned KernelSize = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                line_wr_o,
  output logic [scan_pkg::clog2_min1(ImgWidth)-1:0]  col_o,
  output logic [scan_pkg::clog2_min1(ImgHeight)-1:0] row_o,
  output logic                                busy_o,
  output logic                                frame_done_o
);

  localparam int unsigned ColWidth = clog2_min1(ImgWidth);
  localparam int unsigned RowWidth = clog2_min1(ImgHeight);

  scan_state_e r_state;
  scan_state_e w_state_next;

  logic                w_active;
  logic                w_beat;
  logic                w_col_wrap;
  logic                w_row_wrap;
  logic [ColWidth-1:0] w_col;
  logic [ColWidth-1:0] w_col_next;
  logic [RowWidth-1:0] w_row;
  logic [RowWidth-1:0] w_row_next;

  assign w_active = rst_ni && (r_state == ST_ACTIVE);
  assign ready_o  = w_active && ready_i;
  assign w_beat   = valid_i && ready_o;

  // A counter is at its last position exactly when its incremented value
  // equals the extent (modulo the counter width).
  assign w_col_wrap = w_beat && (w_col_next == ColWidth'(ImgWidth));
  assign w_row_wrap = w_col_wrap && (w_row_next == RowWidth'(ImgHeight));

  counter #(.Width(ColWidth)) u_col_cnt (
    .clk_i        (clk_i),
    .rst_i        (!rst_ni || w_col_wrap),
    .up_i         (w_beat),
    .down_i       (1'b0),
    .count_o      (w_col),
    .next_count_o (w_col_next)
  );

  counter #(.Width(RowWidth)) u_row_cnt (
    .clk_i        (clk_i),
    .rst_i        (!rst_ni || w_row_wrap),
    .up_i         (w_col_wrap),
    .down_i       (1'b0),
    .count_o      (w_row),
    .next_count_o (w_row_next)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_row_wrap) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign valid_o = w_beat
                && (w_row >= RowWidth'(KernelSize - 1))
                && (w_col >= ColWidth'(KernelSize - 1));

  assign line_wr_o    = w_beat;
  assign col_o        = w_col;
  assign row_o        = w_row;
  assign busy_o       = w_active;
  assign frame_done_o = rst_ni && (r_state == ST_DONE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 4x3 frame (kernel 3, plus a kernel-1 twin).
module tb_window_scan_ctrl;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, valid_in, ready_in;
  logic ready_o, valid_o, line_wr_o, busy_o, frame_done_o;
  logic [1:0] col_o, row_o;
  logic k1_ready_o, k1_valid_o, k1_line_wr_o, k1_busy_o, k1_frame_done_o;
  logic [1:0] k1_col_o, k1_row_o;

  window_scan_ctrl #(.ImgWidth(W), .ImgHeight(H), .KernelSize(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid_in),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_in),
    .line_wr_o(line_wr_o), .col_o(col_o), .row_o(row_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  window_scan_ctrl #(.ImgWidth(W), .ImgHeight(H), .KernelSize(1)) dut_k1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid_in),
    .ready_o(k1_ready_o), .valid_o(k1_valid_o), .ready_i(ready_in),
    .line_wr_o(k1_line_wr_o), .col_o(k1_col_o), .row_o(k1_row_o),
    .busy_o(k1_busy_o), .frame_done_o(k1_frame_done_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed statistics, plus a reference position model advanced on each beat.
  int cyc = 0, last_beat_cyc = 0, done_cyc = 0;
  int n_beat, n_lwr, n_val, n_val_bad, n_val_k1, n_done, n_overlap, n_rdy_bad, n_pos_bad;
  int exp_col = 0, exp_row = 0;

  task automatic clr_stats();
    n_beat = 0; n_lwr = 0; n_val = 0; n_val_bad = 0; n_val_k1 = 0;
    n_done = 0; n_overlap = 0; n_rdy_bad = 0; n_pos_bad = 0;
  endtask

  always @(negedge clk) begin
    logic exp_beat, exp_v;
    cyc++;
    if (!rst_n) begin
      exp_col = 0;
      exp_row = 0;
    end else begin
      exp_beat = busy_o && valid_in && ready_in;
      exp_v    = exp_beat && (exp_row >= 2) && (exp_col >= 2);
      if (ready_o !== (busy_o && ready_in)) n_rdy_bad++;
      if (busy_o && ((int'(col_o) != exp_col) || (int'(row_o) != exp_row))) n_pos_bad++;
      if (valid_o !== exp_v) n_val_bad++;
      if (valid_o) n_val++;
      if (k1_valid_o) n_val_k1++;
      if (line_wr_o) n_lwr++;
      if (frame_done_o) begin
        n_done++;
        done_cyc = cyc;
        if (ready_o) n_overlap++;
      end
      if (exp_beat) begin
        n_beat++;
        last_beat_cyc = cyc;
        if (exp_col == W - 1) begin
          exp_col = 0;
          exp_row = (exp_row == H - 1) ? 0 : exp_row + 1;
        end else begin
          exp_col++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!frame_done_o && i < 200) begin
      tick();
      i++;
    end
    check({tag, "_done_seen"}, 32'(frame_done_o), 1);
    @(negedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
    clr_stats();

    // Reset behaviour with upstream/downstream both asserting.
    tick(); tick();
    check("rst_busy",    32'(busy_o), 0);
    check("rst_ready",   32'(ready_o), 0);
    check("rst_valid",   32'(valid_o), 0);
    check("rst_linewr",  32'(line_wr_o), 0);
    check("rst_done",    32'(frame_done_o), 0);
    check("rst_col",     32'(col_o), 0);
    check("rst_row",     32'(row_o), 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy",   32'(busy_o), 0);

    // Full-rate frame.
    clr_stats();
    begin_frame();
    #1;
    check("s1_busy",     32'(busy_o), 1);
    check("s1_ready",    32'(ready_o), 1);
    check("s1_col0",     32'(col_o), 0);
    check("s1_row0",     32'(row_o), 0);
    wait_done("s1");
    check("s1_beats",    32'(n_beat), 12);
    check("s1_linewr",   32'(n_lwr), 12);
    check("s1_valids",   32'(n_val), 2);
    check("s1_valid_pos", 32'(n_val_bad), 0);
    check("s1_k1_valids", 32'(n_val_k1), 12);
    check("s1_pos",      32'(n_pos_bad), 0);
    check("s1_ndone",    32'(n_done), 1);
    check("s1_done_lat", 32'(done_cyc - last_beat_cyc), 1);
    check("s1_overlap",  32'(n_overlap), 0);
    tick();
    check("s1_done_len", 32'(frame_done_o), 0);
    check("s1_idle",     32'(busy_o), 0);
    tick();
    check("s1_stay_idle", 32'(busy_o), 0);

    // Downstream ready toggling every cycle.
    clr_stats();
    ready_in = 1'b0;
    begin_frame();
    for (int i = 0; i < 100 && !frame_done_o; i++) begin
      ready_in = ~ready_in;
      tick();
    end
    check("s2_done_seen", 32'(frame_done_o), 1);
    @(negedge clk); #1;
    ready_in = 1'b1;
    check("s2_beats",    32'(n_beat), 12);
    check("s2_linewr",   32'(n_lwr), 12);
    check("s2_valids",   32'(n_val), 2);
    check("s2_valid_pos", 32'(n_val_bad), 0);
    check("s2_ready",    32'(n_rdy_bad), 0);
    check("s2_pos",      32'(n_pos_bad), 0);
    tick();

    // Upstream stall at (row 1, col 2).
    clr_stats();
    begin_frame();
    for (int i = 0; i < 50 && !(row_o == 2'd1 && col_o == 2'd2); i++) tick();
    valid_in = 1'b0;
    repeat (5) begin
      #1;
      check("s3_hold_col", 32'(col_o), 2);
      check("s3_hold_row", 32'(row_o), 1);
      check("s3_no_wr",    32'(line_wr_o), 0);
      tick();
    end
    valid_in = 1'b1;
    wait_done("s3");
    check("s3_beats",    32'(n_beat), 12);
    check("s3_linewr",   32'(n_lwr), 12);
    check("s3_valids",   32'(n_val), 2);
    check("s3_pos",      32'(n_pos_bad), 0);
    tick();

    // Reset mid-frame after 7 beats.
    clr_stats();
    begin_frame();
    for (int i = 0; i < 50 && !(row_o == 2'd1 && col_o == 2'd3); i++) tick();
    rst_n = 1'b0;
    tick();
    check("s4_rst_busy", 32'(busy_o), 0);
    check("s4_rst_col",  32'(col_o), 0);
    check("s4_rst_row",  32'(row_o), 0);
    rst_n = 1'b1;
    tick();
    check("s4_idle",     32'(busy_o), 0);
    check("s4_no_done",  32'(n_done), 0);
    check("s4_beats7",   32'(n_beat), 7);
    clr_stats();
    begin_frame();
    #1;
    check("s4_restart_col", 32'(col_o), 0);
    check("s4_restart_row", 32'(row_o), 0);
    wait_done("s4");
    check("s4_beats",    32'(n_beat), 12);
    check("s4_ndone",    32'(n_done), 1);
    check("s4_pos",      32'(n_pos_bad), 0);
    tick();

    // start held through DONE, then a stray start pulse mid-frame.
    clr_stats();
    start = 1'b1;
    tick();
    check("s5_busy",     32'(busy_o), 1);
    wait_done("s5a");
    tick();
    check("s5_idle_gap", 32'(busy_o), 0);
    check("s5_done_off", 32'(frame_done_o), 0);
    tick();
    check("s5_rearm",    32'(busy_o), 1);
    check("s5_rearm_col", 32'(col_o), 0);
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s5_stray_col", 32'(col_o), 3);
    check("s5_stray_busy", 32'(busy_o), 1);
    wait_done("s5b");
    check("s5_beats",    32'(n_beat), 24);
    check("s5_ndone",    32'(n_done), 2);
    check("s5_valids",   32'(n_val), 4);
    check("s5_pos",      32'(n_pos_bad), 0);
    tick();
    check("s5_final_idle", 32'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
